// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between WB, the MDU, the hazard unit and the register file.
//
// Handshake: the MDU result channel uses valid/ready. A result transfers on a
// rising clk edge where mdu_valid && mdu_ready are both high. The producer holds
// mdu_reg/mdu_data stable while mdu_valid is high and ready is low. mdu_ready
// never depends on mdu_valid. The WB channel has no ready: wb_we is always
// accepted.
interface regfile_write_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  q_rs;
  logic [4:0]  q_rt;
  logic        rs_pending;
  logic        rt_pending;
  logic        stall_req;

  // Pipeline side: drives requests and queries, observes the port.
  modport master (
    output wb_we, wb_reg, wb_data, mdu_valid, mdu_reg, mdu_data, q_rs, q_rt,
    input  mdu_ready, rf_we, rf_waddr, rf_wdata, rs_pending, rt_pending, stall_req
  );

  // Arbiter side.
  modport slave (
    input  wb_we, wb_reg, wb_data, mdu_valid, mdu_reg, mdu_data, q_rs, q_rt,
    output mdu_ready, rf_we, rf_waddr, rf_wdata, rs_pending, rt_pending, stall_req
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between in-order WB writes and queued
// MDU results. WB always wins. MDU results drain on idle WB cycles. A queued
// result that a granted WB write to the same register overtakes is killed, and
// it is later popped without a write.
module regfile_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input logic                  clk,
  input logic                  rst,
  regfile_write_arbiter_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       q_reg  [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_kill;
  logic [DEPTH-1:0] occupied;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve;

  logic full;
  logic empty;
  logic wb_use;
  logic head_kill;
  logic pop;
  logic drain;
  logic push;
  logic rs_hit;
  logic rt_hit;

  // A WB write to r0 is treated as an idle cycle, so the queue may drain under it.
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign wb_use    = bus.wb_we && (bus.wb_reg != 5'd0);
  assign head_kill = q_kill[rd_ptr];
  assign pop       = !wb_use && !empty;
  assign drain     = pop && !head_kill;
  assign push      = bus.mdu_valid && !full && (bus.mdu_reg != 5'd0);

  // Mark each slot that lies between rd_ptr and rd_ptr+count (modulo DEPTH).
  always_comb begin
    logic [PW-1:0] off;
    occupied = '0;
    off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off         = PW'(i) - rd_ptr;
      occupied[i] = ({1'b0, off} < count);
    end
  end

  // Report a hazard when a live (occupied, not killed) entry matches a query register.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occupied[i] && !q_kill[i] && (q_reg[i] == bus.q_rs)) rs_hit = 1'b1;
      if (occupied[i] && !q_kill[i] && (q_reg[i] == bus.q_rt)) rt_hit = 1'b1;
    end
  end

  assign bus.rs_pending = rs_hit && (bus.q_rs != 5'd0);
  assign bus.rt_pending = rt_hit && (bus.q_rt != 5'd0);
  assign bus.mdu_ready  = !full;
  assign bus.stall_req  = (starve >= SW'(STARVE_LIMIT));
  // Gate rf_we with rst so that a WB request seen during reset cannot write.
  assign bus.rf_we      = !rst && (wb_use || drain);
  assign bus.rf_waddr   = wb_use ? bus.wb_reg  : q_reg[rd_ptr];
  assign bus.rf_wdata   = wb_use ? bus.wb_data : q_data[rd_ptr];

  // Store the payload of an accepted result. This storage needs no reset because occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      q_reg[wr_ptr]  <= bus.mdu_reg;
      q_data[wr_ptr] <= bus.mdu_data;
    end
  end

  // Update the queue pointers and occupancy. Set WAW kill bits for entries that a granted WB write overtakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      q_kill <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_use && (q_reg[i] == bus.wb_reg)) q_kill[i] <= 1'b1;
      end
      // An entry entering on this edge is younger than the WB write, so it stays live.
      if (push) begin
        q_kill[wr_ptr] <= 1'b0;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Count the cycles a live head waits behind WB. The counter saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (empty || pop) begin
      starve <= '0;
    end else if (!head_kill && (starve != SW'(STARVE_LIMIT))) begin
      starve <= starve + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (DEPTH=2, STARVE_LIMIT=8).
module tb_regfile_write_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic wb_we, input logic [4:0] wb_reg, input logic [31:0] wb_data,
                       input logic mv, input logic [4:0] mreg, input logic [31:0] mdata);
    bus.wb_we     = wb_we;
    bus.wb_reg    = wb_reg;
    bus.wb_data   = wb_data;
    bus.mdu_valid = mv;
    bus.mdu_reg   = mreg;
    bus.mdu_data  = mdata;
  endtask

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    bus.q_rs = 5'd4;
    bus.q_rt = 5'd0;
    drive(1'b1, 5'd4, 32'hdead, 1'b0, 5'd0, 32'h0);
    #2;
    // reset state: a WB request during reset must not write
    check("rst_rf_we",     32'(bus.rf_we),      32'd0);
    check("rst_mdu_ready", 32'(bus.mdu_ready),  32'd1);
    check("rst_stall",     32'(bus.stall_req),  32'd0);
    check("rst_rs_pend",   32'(bus.rs_pending), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();

    // push r5 with WB idle, drains one cycle later
    bus.q_rs = 5'd5;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1111);
    settle();
    check("t2_ready",     32'(bus.mdu_ready),  32'd1);
    check("t2_rf_we0",    32'(bus.rf_we),      32'd0);
    check("t2_pend0",     32'(bus.rs_pending), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    settle();
    check("t2_rf_we",     32'(bus.rf_we),      32'd1);
    check("t2_waddr",     32'(bus.rf_waddr),   32'd5);
    check("t2_wdata",     bus.rf_wdata,        32'h1111);
    check("t2_pend1",     32'(bus.rs_pending), 32'd1);
    tick();
    settle();
    check("t2_idle",      32'(bus.rf_we),      32'd0);
    check("t2_pend_clr",  32'(bus.rs_pending), 32'd0);

    // WAW: queued r5 overtaken by WB r5
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd5, 32'haaaa);
    settle();
    check("t3_wb_addr",   32'(bus.rf_waddr),   32'd9);
    tick();
    drive(1'b1, 5'd5, 32'h2222, 1'b0, 5'd0, 32'h0);
    settle();
    check("t3_wb_data",   bus.rf_wdata,        32'h2222);
    check("t3_wb_waddr",  32'(bus.rf_waddr),   32'd5);
    check("t3_pend_pre",  32'(bus.rs_pending), 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    settle();
    check("t3_pend_kill", 32'(bus.rs_pending), 32'd0);
    check("t3_kill_pop",  32'(bus.rf_we),      32'd0);
    tick();
    settle();
    check("t3_empty_we",  32'(bus.rf_we),      32'd0);
    // same-cycle enqueue to the WB register survives
    drive(1'b1, 5'd5, 32'h3333, 1'b1, 5'd5, 32'hbbbb);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    settle();
    check("t3_young_we",  32'(bus.rf_we),      32'd1);
    check("t3_young_dat", bus.rf_wdata,        32'hbbbb);
    tick();

    // starvation: r7 queued, WB busy on r3 for 12 cycles
    bus.q_rs = 5'd7;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h7777);
    tick();
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'h0);
      settle();
      check($sformatf("t4_stall_%0d", k), 32'(bus.stall_req), (k >= 9) ? 32'd1 : 32'd0);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    settle();
    check("t4_drain_we",  32'(bus.rf_we),      32'd1);
    check("t4_drain_adr", 32'(bus.rf_waddr),   32'd7);
    check("t4_drain_dat", bus.rf_wdata,        32'h7777);
    check("t4_stall_hi",  32'(bus.stall_req),  32'd1);
    tick();
    settle();
    check("t4_stall_clr", 32'(bus.stall_req),  32'd0);
    check("t4_idle",      32'(bus.rf_we),      32'd0);

    // fill DEPTH=2 with WB busy; third result waits for a pop
    bus.q_rt = 5'd2;
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd1, 32'h11);
    tick();
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd2, 32'h22);
    settle();
    check("t5_ready1",    32'(bus.mdu_ready),  32'd1);
    tick();
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd3, 32'h33);
    settle();
    check("t5_full",      32'(bus.mdu_ready),  32'd0);
    check("t5_rt_pend",   32'(bus.rt_pending), 32'd1);
    tick();
    settle();
    check("t5_hold",      32'(bus.mdu_ready),  32'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33);
    settle();
    check("t5_pop1_adr",  32'(bus.rf_waddr),   32'd1);
    check("t5_pop1_dat",  bus.rf_wdata,        32'h11);
    check("t5_full_pop",  32'(bus.mdu_ready),  32'd0);
    tick();
    settle();
    check("t5_ready2",    32'(bus.mdu_ready),  32'd1);
    check("t5_pop2_we",   32'(bus.rf_we),      32'd1);
    check("t5_pop2_adr",  32'(bus.rf_waddr),   32'd2);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    settle();
    check("t5_pop3_adr",  32'(bus.rf_waddr),   32'd3);
    check("t5_pop3_dat",  bus.rf_wdata,        32'h33);
    tick();
    settle();
    check("t5_empty_we",  32'(bus.rf_we),      32'd0);
    check("t5_rt_clr",    32'(bus.rt_pending), 32'd0);

    // reset asserted mid-drain with two entries queued
    bus.q_rs = 5'd4;
    bus.q_rt = 5'd6;
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd4, 32'h44);
    tick();
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd6, 32'h66);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    settle();
    check("t1_pre_we",    32'(bus.rf_we),      32'd1);
    rst = 1'b1;
    settle();
    check("t1_rst_we",    32'(bus.rf_we),      32'd0);
    check("t1_rst_ready", 32'(bus.mdu_ready),  32'd1);
    check("t1_rst_rs",    32'(bus.rs_pending), 32'd0);
    check("t1_rst_rt",    32'(bus.rt_pending), 32'd0);
    tick();
    rst = 1'b0;
    settle();
    check("t1_post_we",   32'(bus.rf_we),      32'd0);
    tick();
    settle();
    check("t1_post_we2",  32'(bus.rf_we),      32'd0);

    // r0 on both sides: nothing stored, no write
    bus.q_rs = 5'd0;
    bus.q_rt = 5'd0;
    drive(1'b1, 5'd0, 32'h5555, 1'b1, 5'd0, 32'h6666);
    settle();
    check("t6_rf_we",     32'(bus.rf_we),      32'd0);
    check("t6_ready",     32'(bus.mdu_ready),  32'd1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    settle();
    check("t6_no_drain",  32'(bus.rf_we),      32'd0);
    check("t6_rs_pend",   32'(bus.rs_pending), 32'd0);
    check("t6_rt_pend",   32'(bus.rt_pending), 32'd0);
    tick();

    // report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
